// File: rtl/gameplay_pkg.sv
// Shared gameplay definitions used by the renderer.
// Holds the screen geometry, the erase colour, the named colour codes and the
// render FSM state encoding. There are no ports; modules import this package.
package gameplay_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  localparam logic [2:0] BG_COLOUR = COL_BLACK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } render_state_t;

endpackage

// File: rtl/block_renderer_rect_scanner.sv
// Row-major rectangle scanner: cx counts 0..BLOCK_W-1 (inner), cy counts
// 0..BLOCK_H-1 (outer), advancing one position per cycle while step is high.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : return both counters to zero (wins over step)
//   step       : advance to the next pixel position
//   cx, cy     : current pixel offset inside the rectangle
//   last       : high while the counters sit on the final pixel
module rect_scanner #(
  parameter int BLOCK_W = 20,
  parameter int BLOCK_H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  output logic [4:0] cx,
  output logic [3:0] cy,
  output logic       last
);

  localparam logic [4:0] CX_MAX = 5'(BLOCK_W - 1);
  localparam logic [3:0] CY_MAX = 4'(BLOCK_H - 1);

  logic [4:0] cx_q;
  logic [3:0] cy_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (step) begin
      if (cx_q == CX_MAX) begin
        cx_q <= '0;
        cy_q <= (cy_q == CY_MAX) ? 4'd0 : cy_q + 4'd1;
      end else begin
        cx_q <= cx_q + 5'd1;
      end
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == CX_MAX) && (cy_q == CY_MAX);

endmodule

// File: rtl/block_renderer.sv
// Block renderer: turns the current block position into a pixel stream for
// the VGA adapter. Each request first erases the previously drawn rectangle
// (unless keep marks the old block as landed) and then draws the new one.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start, keep           : render request and erase suppression (IDLE only)
//   new_x, new_y          : left/top edge of the block
//   colour_in             : block colour
//   x, y, colour, plot    : registered pixel write to the VGA adapter
//   busy                  : frame in progress
//   done                  : one-cycle completion pulse
module block_renderer
  import gameplay_pkg::*;
#(
  parameter int         BLOCK_W   = 20,
  parameter int         BLOCK_H   = 4,
  parameter int         SCREEN_W  = gameplay_pkg::SCREEN_W,
  parameter int         SCREEN_H  = gameplay_pkg::SCREEN_H,
  parameter logic [2:0] BG_COLOUR = gameplay_pkg::BG_COLOUR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       keep,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [8:0] SCR_W9 = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8 = 8'(SCREEN_H);

  // Sums are one bit wider than the screen coordinates, so a block hanging
  // off the right/bottom edge is clipped instead of wrapping to column 0.
  function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
    return (sx < SCR_W9) && (sy < SCR_H8);
  endfunction

  render_state_t state_q;
  logic [7:0] lat_x_q, last_x_q;
  logic [6:0] lat_y_q, last_y_q;
  logic [2:0] lat_col_q;
  logic       have_last_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q, busy_q, done_q;

  logic [4:0] cx;
  logic [3:0] cy;
  logic       scan_last;
  logic       scanning_d, erasing_d, scan_clear_d;
  logic [7:0] base_x_d;
  logic [6:0] base_y_d;
  logic [8:0] sum_x_d;
  logic [7:0] sum_y_d;

  assign erasing_d    = (state_q == ST_ERASE);
  assign scanning_d   = erasing_d || (state_q == ST_DRAW);
  // Counters are held at zero between frames and rewound between phases.
  assign scan_clear_d = !scanning_d || scan_last;

  rect_scanner #(
    .BLOCK_W (BLOCK_W),
    .BLOCK_H (BLOCK_H)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .clear (scan_clear_d),
    .step  (scanning_d),
    .cx    (cx),
    .cy    (cy),
    .last  (scan_last)
  );

  // Address stage: pixel position from the counters, registered below
  assign base_x_d = erasing_d ? last_x_q : lat_x_q;
  assign base_y_d = erasing_d ? last_y_q : lat_y_q;
  assign sum_x_d  = {1'b0, base_x_d} + {4'b0, cx};
  assign sum_y_d  = {1'b0, base_y_d} + {4'b0, cy};

  // Output stage: FSM and registered pixel write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      have_last_q <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      if (scanning_d) begin
        x_q      <= sum_x_d[7:0];
        y_q      <= sum_y_d[6:0];
        colour_q <= erasing_d ? BG_COLOUR : lat_col_q;
        plot_q   <= on_screen(sum_x_d, sum_y_d);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            lat_x_q   <= new_x;
            lat_y_q   <= new_y;
            lat_col_q <= colour_in;
            busy_q    <= 1'b1;
            state_q   <= (have_last_q && !keep) ? ST_ERASE : ST_DRAW;
          end
        end
        ST_ERASE: begin
          if (scan_last) state_q <= ST_DRAW;
        end
        ST_DRAW: begin
          if (scan_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          last_x_q    <= lat_x_q;
          last_y_q    <= lat_y_q;
          have_last_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_block_renderer.sv
// Self-checking bench for block_renderer. A frame-level model turns each
// accepted request into the list of per-cycle outputs it must produce; a
// compare process checks the DUT against that list on every cycle, and
// directed frames pin plot counts, done latency and first pixels to literals.
module tb_block_renderer;

  localparam int BW = 20;
  localparam int BH = 4;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       keep = 1'b0;
  logic [7:0] new_x = '0;
  logic [6:0] new_y = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  block_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .keep      (keep),
    .new_x     (new_x),
    .new_y     (new_y),
    .colour_in (colour_in),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       busy;
    logic       done;
  } rec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   e0 = 0;
  rec_t q[$];
  logic cur_busy = 1'b0;
  logic have_last = 1'b0;
  int   lx = 0, ly = 0;

  int         plot_total = 0;
  int         done_total = 0;
  int         done_k = 0;
  logic [7:0] plx [0:2047];
  logic [6:0] ply [0:2047];
  logic [2:0] plc [0:2047];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rec_t mk(input logic p, input int px, input int py,
                              input logic [2:0] c, input logic d);
    rec_t r;
    r.plot = p;
    r.x    = 8'(px);
    r.y    = 7'(py);
    r.c    = c;
    r.busy = 1'b1;
    r.done = d;
    return r;
  endfunction

  // One output cycle per rectangle pixel, off-screen pixels not plotted.
  function automatic void push_rect(input int bx, input int by, input logic [2:0] c);
    for (int ry = 0; ry < BH; ry++)
      for (int rx = 0; rx < BW; rx++)
        q.push_back(mk((bx + rx < SW) && (by + ry < SH), bx + rx, by + ry, c, 1'b0));
  endfunction

  // Model: request acceptance only when the current cycle is idle.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      have_last = 1'b0;
    end else if (!cur_busy && start) begin
      rec_t r;
      e0 = cyc;
      q.push_back(mk(1'b0, 0, 0, 3'b000, 1'b0));
      if (have_last && !keep) push_rect(lx, ly, 3'b000);
      push_rect(int'(new_x), int'(new_y), colour_in);
      r = q.pop_back();
      r.done = 1'b1;
      q.push_back(r);
      lx = int'(new_x);
      ly = int'(new_y);
      have_last = 1'b1;
    end
  end

  // Compare process, sampled mid-cycle.
  always @(negedge clk) begin
    rec_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = '{plot: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, busy: 1'b0, done: 1'b0};
    cur_busy = e.busy;
    if (!reset) begin
      chk("plot", plot, e.plot);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      if (e.plot) begin
        chk("x", x, e.x);
        chk("y", y, e.y);
        chk("colour", colour, e.c);
      end
    end
    if (plot === 1'b1) begin
      plx[plot_total % 2048] = x;
      ply[plot_total % 2048] = y;
      plc[plot_total % 2048] = colour;
      plot_total++;
    end
    if (done === 1'b1) begin
      done_total++;
      done_k = cyc - e0 + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic launch(input int nx, input int ny, input logic [2:0] c, input logic k);
    new_x = 8'(nx);
    new_y = 7'(ny);
    colour_in = c;
    keep = k;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done_total == d0 && n < 400) begin
      tick(1);
      n++;
    end
    if (done_total == d0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic frame(input string name, input int nx, input int ny, input logic [2:0] c,
                       input logic k, input int exp_plots, input int exp_k,
                       input int fx, input int fy, input int fc);
    int p0 = plot_total;
    int d0 = done_total;
    launch(nx, ny, c, k);
    wait_done(name, d0);
    tick(3);
    chk({name, "_plots"}, plot_total - p0, exp_plots);
    chk({name, "_dones"}, done_total - d0, 1);
    chk({name, "_done_cycle"}, done_k, exp_k);
    chk({name, "_first_x"}, plx[p0 % 2048], fx);
    chk({name, "_first_y"}, ply[p0 % 2048], fy);
    chk({name, "_first_c"}, plc[p0 % 2048], fc);
  endtask

  initial begin
    int p0, d0;
    tick(3);
    do_reset();
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // First frame: no erase.
    frame("A", 10, 100, 3'b100, 1'b0, 80, 81, 10, 100, 4);
    chk("A_last_x", plx[(plot_total - 1) % 2048], 29);
    chk("A_last_y", ply[(plot_total - 1) % 2048], 103);

    // Move: erase old, draw new.
    frame("B", 30, 100, 3'b100, 1'b0, 160, 161, 10, 100, 0);
    chk("B_last_x", plx[(plot_total - 1) % 2048], 49);
    chk("B_last_y", ply[(plot_total - 1) % 2048], 103);

    // Landed block kept; next move erases the new rectangle at y=96.
    frame("C", 30, 96, 3'b010, 1'b1, 80, 81, 30, 96, 2);
    frame("D", 30, 100, 3'b010, 1'b0, 160, 161, 30, 96, 0);

    // Clipping at the bottom-right corner.
    do_reset();
    frame("CLIP", 150, 118, 3'b001, 1'b0, 20, 81, 150, 118, 1);
    chk("CLIP_last_x", plx[(plot_total - 1) % 2048], 159);
    chk("CLIP_last_y", ply[(plot_total - 1) % 2048], 119);

    // Repeated start requests while busy are ignored.
    p0 = plot_total;
    d0 = done_total;
    launch(50, 50, 3'b011, 1'b0);
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(34);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("REP", d0);
    tick(3);
    chk("REP_plots", plot_total - p0, 100);
    chk("REP_dones", done_total - d0, 1);
    chk("REP_done_cycle", done_k, 161);

    // Reset in the middle of a draw.
    do_reset();
    d0 = done_total;
    launch(20, 20, 3'b110, 1'b0);
    tick(29);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("MIDRST_plot", plot, 0);
    chk("MIDRST_busy", busy, 0);
    tick(5);
    chk("MIDRST_dones", done_total - d0, 0);
    frame("AFTER", 40, 60, 3'b111, 1'b0, 80, 81, 40, 60, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
